// File: rtl/scan_pkg.sv
// Shared constants for the multiplexed-display anode scanner: drive levels,
// parameter defaults, legal parameter ranges and width helpers.
package scan_pkg;

  // Anode drive levels (common-anode display through PNP drivers: low = lit)
  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  // Parameter defaults
  localparam int DIGITS_DEF   = 4;
  localparam int PRESCALE_DEF = 100000;

  // Legal parameter ranges
  localparam int DIGITS_MIN   = 2;
  localparam int DIGITS_MAX   = 8;
  localparam int PRESCALE_MIN = 1;

  // Encoding of the dir input
  typedef enum logic {
    SCAN_UP   = 1'b0,
    SCAN_DOWN = 1'b1
  } scan_dir_e;

  // Width of the digit index: clog2(digits), never less than one bit
  function automatic int sel_width(input int digits);
    return (digits > 2) ? $clog2(digits) : 1;
  endfunction

  // Width of the prescaler count: clog2(prescale), never less than one bit
  function automatic int cnt_width(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell-time prescaler: counts 0..PRESCALE-1 on enabled cycles and flags the
// wrap cycle as tick. The count is held (not restarted) while enable is low.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic enable,
  input  logic sync_clr,
  output logic tick
);

  localparam int               CNT_W = cnt_width(PRESCALE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  if (PRESCALE < PRESCALE_MIN) begin : g_bad_prescale
    $error("scan_prescaler: PRESCALE must be >= 1");
  end

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  // With PRESCALE=1 LAST is 0, so at_last is always true and every enabled
  // cycle ticks. A coincident sync_clr wins over the tick.
  assign at_last = (cnt == LAST);
  assign tick    = enable & at_last & ~sync_clr;

  // Dwell counter: clear has priority, otherwise advance/wrap when enabled
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/anode_scan_ctrl.sv
// Multiplexed-display anode scanner. Steps a digit index up or down once per
// prescaler dwell and drives an active-low one-hot anode bus, with per-digit
// blanking. digit_sel, anode, digit_tick and frame_done are all registered
// on the same edge so they stay mutually aligned.
module anode_scan_ctrl
  import scan_pkg::*;
#(
  parameter  int DIGITS   = DIGITS_DEF,
  parameter  int PRESCALE = PRESCALE_DEF,
  localparam int SEL_W    = sel_width(DIGITS)
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              dir,
  input  logic              sync_clr,
  input  logic [DIGITS-1:0] blank_mask,
  output logic [SEL_W-1:0]  digit_sel,
  output logic [DIGITS-1:0] anode,
  output logic              digit_tick,
  output logic              frame_done
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("anode_scan_ctrl: DIGITS must be in 2..8");
  end

  logic              tick;
  logic [SEL_W-1:0]  sel_step;
  logic              sel_wrap;
  logic [SEL_W-1:0]  sel_next;
  logic [DIGITS-1:0] anode_next;

  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .enable   (enable),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  // Neighbouring digit in the current direction, and whether that step wraps.
  // The up-compare uses >= so an out-of-range index can never persist.
  always_comb begin
    sel_step = digit_sel;
    sel_wrap = 1'b0;
    if (dir == SCAN_DOWN) begin
      if (digit_sel == '0 || digit_sel > SEL_LAST) begin
        sel_step = SEL_LAST;
        sel_wrap = 1'b1;
      end else begin
        sel_step = digit_sel - SEL_W'(1);
      end
    end else begin
      if (digit_sel >= SEL_LAST) begin
        sel_step = '0;
        sel_wrap = 1'b1;
      end else begin
        sel_step = digit_sel + SEL_W'(1);
      end
    end
  end

  // Index to register this edge, and the anode pattern decoded from it so the
  // anode bus lands together with digit_sel rather than a cycle behind.
  always_comb begin
    sel_next = digit_sel;
    if (sync_clr) begin
      sel_next = '0;
    end else if (tick) begin
      sel_next = sel_step;
    end
    anode_next = {DIGITS{ANODE_OFF}};
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_next == SEL_W'(i) && !blank_mask[i]) begin
        anode_next[i] = ANODE_ON;
      end
    end
  end

  // Output registers; pulses are only raised by a tick that sync_clr did not
  // override (the prescaler already masks tick with sync_clr).
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      digit_sel  <= '0;
      anode      <= {DIGITS{ANODE_OFF}};
      digit_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit_sel  <= sel_next;
      anode      <= anode_next;
      digit_tick <= tick & ~sync_clr;
      frame_done <= tick & ~sync_clr & sel_wrap;
    end
  end

endmodule

// File: doc/anode_scan_ctrl.md
ANODE_SCAN_CTRL -- requirements
Module: anode_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, is the number of multiplexed digits; legal range 2..8.
REQ-002 Parameter PRESCALE, default 100000, is the number of enabled clock cycles per digit dwell; legal range >= 1.
REQ-003 Derived localparam SEL_W = max(1, clog2(DIGITS)) SHALL be the width of the digit index.
REQ-004 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset is asynchronous and active-low.
REQ-006 enable  input  1  1 = scanning advances; 0 = prescaler and index frozen.
REQ-007 dir  input  1  0 = scan up, 1 = scan down.
REQ-008 sync_clr  input  1  synchronous clear of prescaler and index.
REQ-009 blank_mask  input  DIGITS  bit i = 1 forces digit i dark.
REQ-010 digit_sel  output  SEL_W  current digit index, registered.
REQ-011 anode  output  DIGITS  active-low one-hot anode drive, registered.
REQ-012 digit_tick  output  1  one-cycle pulse marking a digit_sel change.
REQ-013 frame_done  output  1  one-cycle pulse marking a full-frame wrap.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 while enable=1, wrapping to 0; the wrap cycle is the internal tick; PRESCALE=1 SHALL tick every enabled cycle.
REQ-015 enable=0 SHALL hold prescaler, digit_sel and anode-select unchanged; on re-enable the prescaler resumes from its held value (no restart).
REQ-016 On tick with dir=0, digit_sel SHALL increment, wrapping DIGITS-1 -> 0.
REQ-017 On tick with dir=1, digit_sel SHALL decrement, wrapping 0 -> DIGITS-1.
REQ-018 digit_sel SHALL never hold a value >= DIGITS, including for non-power-of-two DIGITS.
REQ-019 digit_tick SHALL be high for exactly the one cycle in which digit_sel first shows its new value (same-edge registration).
REQ-020 frame_done SHALL pulse, coincident with digit_tick, only on the wrap transition (up: to 0; down: to DIGITS-1).
REQ-021 anode[i] SHALL be 0 iff i == digit_sel and blank_mask[i] == 0, otherwise 1; anode is aligned with digit_sel, and a blank_mask change appears on anode one cycle later.
REQ-022 dir changes SHALL take effect on the next tick, without disturbing the prescaler.
REQ-023 sync_clr=1 SHALL, on that edge, set prescaler and digit_sel to 0 and suppress digit_tick and frame_done, overriding enable and any coincident tick.
REQ-024 All arithmetic SHALL be unsigned; the prescaler register width is clog2(PRESCALE), minimum 1 bit.

Reset
REQ-025 reset_n=0 SHALL immediately, without a clock edge, force prescaler=0, digit_sel=0, anode=all ones, digit_tick=0 and frame_done=0.
REQ-026 After reset_n deasserts, the first clock edge SHALL drive anode from digit_sel=0 and blank_mask; the first tick occurs PRESCALE enabled cycles later.
REQ-027 Assertion of reset_n mid-dwell SHALL discard the partial prescaler count.

Structure
REQ-028 Shared package scan_pkg SHALL hold ANODE_ON/ANODE_OFF level constants, the DIGITS/PRESCALE defaults and the legal-range limits.
REQ-029 Prescaler SHALL be a sub-module scan_prescaler (inputs clk_in, reset_n, enable, sync_clr; output tick; parameter PRESCALE).
REQ-030 Illegal parameter values SHALL be rejected at elaboration.

Verification (DIGITS=4, PRESCALE=3 unless stated)
REQ-031 Up scan, enable=1, dir=0 -> digit_sel 0,1,2,3,0 changing every 3 cycles; anode 1110,1101,1011,0111,1110; frame_done only on 3->0.
REQ-032 DIGITS=3, dir=1 -> digit_sel 0,2,1,0; value 3 never appears; frame_done on 0->2.
REQ-033 enable=0 for 10 cycles one cycle after a tick -> all outputs frozen; after re-enable the next tick arrives 2 cycles later.
REQ-034 blank_mask=0010 while digit_sel=1 -> anode=1111 on the next cycle; digit_sel keeps advancing; clearing the mask restores 1101.
REQ-035 sync_clr coincident with a tick at digit_sel=2 -> digit_sel=0, no digit_tick or frame_done pulse; asynchronous reset_n low mid-dwell -> outputs reach reset values before the next clk_in edge.
REQ-036 DIGITS=2, PRESCALE=1 -> digit_sel toggles every cycle, digit_tick is held high, and frame_done pulses every second cycle.
